// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types and width helpers for the ADC scan sequencer/averager
package adc_seq_pkg;

    localparam int CH_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } seq_state_t;

    // Accumulator width: a full window of max-scale samples cannot overflow.
    function automatic int acc_w(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

    // Slot index width; a single-channel scan still gets a 1-bit slot field.
    function automatic int slot_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/adc_seq_avg_if.sv
// rtl/adc_seq_avg_if.sv - ADC command/response and averaged-result streams (res_min/res_max with ADC_SEQ_MINMAX_EN)
interface adc_seq_avg_if #(
    parameter int CH_W   = 5,
    parameter int DATA_W = 12,
    parameter int SLOT_W = 3
);
    logic              cmd_valid;
    logic [CH_W-1:0]   cmd_channel;
    logic              cmd_startofpacket;
    logic              cmd_endofpacket;
    logic              cmd_ready;

    logic              rsp_valid;
    logic [CH_W-1:0]   rsp_channel;
    logic [DATA_W-1:0] rsp_data;

    logic              res_valid;
    logic              res_ready;
    logic [SLOT_W-1:0] res_slot;
    logic [DATA_W-1:0] res_data;
`ifdef ADC_SEQ_MINMAX_EN
    logic [DATA_W-1:0] res_min;
    logic [DATA_W-1:0] res_max;
`endif

    // Sequencer side
    modport master (
        output cmd_valid, cmd_channel, cmd_startofpacket, cmd_endofpacket,
        input  cmd_ready,
        input  rsp_valid, rsp_channel, rsp_data,
        output res_valid, res_slot, res_data,
`ifdef ADC_SEQ_MINMAX_EN
        output res_min, res_max,
`endif
        input  res_ready
    );

    // ADC system and result consumer side
    modport slave (
        input  cmd_valid, cmd_channel, cmd_startofpacket, cmd_endofpacket,
        output cmd_ready,
        output rsp_valid, rsp_channel, rsp_data,
        input  res_valid, res_slot, res_data,
`ifdef ADC_SEQ_MINMAX_EN
        input  res_min, res_max,
`endif
        output res_ready
    );

endinterface

// File: rtl/adc_seq_acc.sv
// rtl/adc_seq_acc.sv - per-channel sample accumulator, window counter and optional min/max tracker (ADC_SEQ_MINMAX_EN)
module adc_seq_acc
    import adc_seq_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              add,
    input  logic [DATA_W-1:0] sample,
    output logic              done,
    output logic [DATA_W-1:0] avg
`ifdef ADC_SEQ_MINMAX_EN
    ,
    output logic [DATA_W-1:0] smin,
    output logic [DATA_W-1:0] smax
`endif
);

    localparam int ACC_W = acc_w(DATA_W, AVG_LOG2);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    // Sum and sample count for the current window; clear wins over add.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (add) begin
            acc <= acc + ACC_W'(sample);
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The add being presented now closes the window.
    assign done = (cnt == CNT_LAST);

    // Truncating divide by the window length.
    assign avg = acc[ACC_W-1:AVG_LOG2];

`ifdef ADC_SEQ_MINMAX_EN
    // Extremes of the window, restarted with every clear.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            smin <= '1;
            smax <= '0;
        end else if (add) begin
            if (sample < smin) smin <= sample;
            if (sample > smax) smax <= sample;
        end
    end
`endif

endmodule

// File: rtl/adc_seq_avg.sv
// rtl/adc_seq_avg.sv - round-robin ADC scan sequencer with per-channel averaging (option: ADC_SEQ_MINMAX_EN)
module adc_seq_avg
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int CH_BASE  = 1,
    parameter int CH_W     = CH_W_DEF,
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 4
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic          enable,
    output logic          busy,
    output logic          err_sticky,
    adc_seq_avg_if.master bus
);

    localparam int SLOT_W = slot_w(NUM_CH);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [SLOT_W-1:0] slot;
    logic [CH_W-1:0]   slot_ch;
    logic              rsp_ok;
    logic              emit_done;
    logic              acc_clear;
    logic              acc_done;
    logic [DATA_W-1:0] acc_avg;
`ifdef ADC_SEQ_MINMAX_EN
    logic [DATA_W-1:0] acc_min;
    logic [DATA_W-1:0] acc_max;
`endif

    assign slot_ch   = CH_W'(CH_BASE) + CH_W'(slot);
    assign rsp_ok    = (state == ST_WAIT) && bus.rsp_valid && (bus.rsp_channel == slot_ch);
    assign emit_done = (state == ST_EMIT) && bus.res_ready;
    assign acc_clear = (state == ST_IDLE) || emit_done;

    adc_seq_acc #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .clk    (clk_clk),
        .resetn (reset_reset_n),
        .clear  (acc_clear),
        .add    (rsp_ok),
        .sample (bus.rsp_data),
        .done   (acc_done),
        .avg    (acc_avg)
`ifdef ADC_SEQ_MINMAX_EN
        ,
        .smin   (acc_min),
        .smax   (acc_max)
`endif
    );

    // State register.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) state <= ST_IDLE;
        else                state <= state_next;
    end

    // Next-state: one command outstanding; enable only matters at channel boundaries.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (enable) state_next = ST_ISSUE;
            ST_ISSUE: if (bus.cmd_ready) state_next = ST_WAIT;
            ST_WAIT: begin
                if (rsp_ok) state_next = acc_done ? ST_EMIT : ST_ISSUE;
            end
            ST_EMIT: begin
                if (bus.res_ready) state_next = enable ? ST_ISSUE : ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state; result fields come from stable accumulator registers.
    always_comb begin
        busy                  = (state != ST_IDLE);
        bus.cmd_valid         = (state == ST_ISSUE);
        bus.cmd_startofpacket = (state == ST_ISSUE);
        bus.cmd_endofpacket   = (state == ST_ISSUE);
        bus.cmd_channel       = slot_ch;
        bus.res_valid         = (state == ST_EMIT);
        bus.res_slot          = slot;
        bus.res_data          = (state == ST_EMIT) ? acc_avg : '0;
`ifdef ADC_SEQ_MINMAX_EN
        bus.res_min           = acc_min;
        bus.res_max           = acc_max;
`endif
    end

    // Scan slot advances once the consumer takes a result.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            slot <= '0;
        end else if (emit_done) begin
            slot <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
        end
    end

    // Any response not consumed as the expected sample is an error.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) err_sticky <= 1'b0;
        else if (bus.rsp_valid && !rsp_ok) err_sticky <= 1'b1;
    end

endmodule
